// File: rtl/mux_2x1_10_pkg.sv
// Shared constants for the write-back 2:1 selector.
// Optional feature macro: MUX_2X1_10_SELCNT_EN (select-toggle counter).
package mux_2x1_10_pkg;

  localparam int unsigned DEFAULT_WIDTH = 10;

  // Select encodings: SEL_A picks the ALU result, SEL_B the memory data
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Select-toggle counter geometry
  localparam int unsigned TOG_W = 8;
  localparam logic [TOG_W-1:0] TOG_MAX = {TOG_W{1'b1}};

  // Saturating increment for the toggle counter
  function automatic logic [TOG_W-1:0] tog_sat_inc(input logic [TOG_W-1:0] cnt);
    if (cnt == TOG_MAX) begin
      return cnt;
    end
    return cnt + TOG_W'(1);
  endfunction

endpackage

// File: rtl/mux_2x1_10_if.sv
// Data/select bundle between the write-back stage and the selector.
// Optional feature macro: MUX_2X1_10_SELCNT_EN adds sel_toggles.
interface mux_2x1_10_if
  import mux_2x1_10_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             SW;
  logic             en;
  logic [WIDTH-1:0] mout;
  logic [WIDTH-1:0] mout_q;
  logic             q_valid;
`ifdef MUX_2X1_10_SELCNT_EN
  logic [TOG_W-1:0] sel_toggles;
`endif

  // Producer side: drives data/select, observes results
  modport master (
    output A,
    output B,
    output SW,
    output en,
    input  mout,
    input  mout_q,
    input  q_valid
`ifdef MUX_2X1_10_SELCNT_EN
    , input sel_toggles
`endif
  );

  // Selector side
  modport slave (
    input  A,
    input  B,
    input  SW,
    input  en,
    output mout,
    output mout_q,
    output q_valid
`ifdef MUX_2X1_10_SELCNT_EN
    , output sel_toggles
`endif
  );

endinterface

// File: rtl/mux_2x1_10_core.sv
// Combinational WIDTH-wide 2:1 selector.
module mux_2x1_10_core
  import mux_2x1_10_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y_c
);

  // Single select steers every bit; an unknown select merges a/b per ternary rules
  assign y_c = (sel == SEL_B) ? b : a;

endmodule

// File: rtl/mux_2x1_10.sv
// Write-back result selector: combinational mout plus enable-gated capture.
// Optional feature macro: MUX_2X1_10_SELCNT_EN (8-bit saturating SW toggle counter).
module mux_2x1_10
  import mux_2x1_10_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_2x1_10_if.slave   bus
);

  logic [WIDTH-1:0] mout_c;
  logic [WIDTH-1:0] mout_q;
  logic             q_valid;

  mux_2x1_10_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a   (bus.A),
    .b   (bus.B),
    .sel (bus.SW),
    .y_c (mout_c)
  );

  assign bus.mout    = mout_c;
  assign bus.mout_q  = mout_q;
  assign bus.q_valid = q_valid;

  // Capture the selected word when enabled; q_valid is sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mout_q  <= '0;
      q_valid <= 1'b0;
    end else if (bus.en) begin
      mout_q  <= mout_c;
      q_valid <= 1'b1;
    end
  end

`ifdef MUX_2X1_10_SELCNT_EN
  logic             sw_q;
  logic [TOG_W-1:0] sel_toggles;

  assign bus.sel_toggles = sel_toggles;

  // Count SW transitions against a registered copy, saturating at TOG_MAX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_q        <= SEL_A;
      sel_toggles <= '0;
    end else begin
      sw_q <= bus.SW;
      if (bus.SW != sw_q) begin
        sel_toggles <= tog_sat_inc(sel_toggles);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mux_2x1_10.sv
// Directed bench for mux_2x1_10; covers the counter when MUX_2X1_10_SELCNT_EN is defined.
module tb_mux_2x1_10;
  import mux_2x1_10_pkg::*;

  localparam int unsigned WIDTH = 10;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mux_2x1_10_if #(.WIDTH(WIDTH)) bus ();

  mux_2x1_10 #(
    .WIDTH (WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // 10 time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling/driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.A    = '0;
    bus.B    = '0;
    bus.SW   = 1'b0;
    bus.en   = 1'b0;
    #2;
    check("reset_mout_q", 32'(bus.mout_q), 32'h0);
    check("reset_q_valid", 32'(bus.q_valid), 32'h0);

    // Combinational selection, no clock involved
    bus.A  = 10'b0000000001;
    bus.B  = 10'b0000000000;
    bus.SW = 1'b0;
    #1;
    check("comb_sel_a", 32'(bus.mout), 32'h1);
    bus.SW = 1'b1;
    #1;
    check("comb_sel_b", 32'(bus.mout), 32'h0);

    // Reset dominates en=1
    bus.A  = 10'h3FF;
    bus.SW = 1'b0;
    bus.en = 1'b1;
    tick();
    check("rst_dominates_q", 32'(bus.mout_q), 32'h0);
    check("rst_dominates_v", 32'(bus.q_valid), 32'h0);

    // Release and load 0x3FF on the first edge with rst_n=1
    rst_n = 1'b1;
    tick();
    check("first_cap_q", 32'(bus.mout_q), 32'h3FF);
    check("first_cap_v", 32'(bus.q_valid), 32'h1);

    // Asynchronous reset mid-cycle
    bus.en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_q", 32'(bus.mout_q), 32'h0);
    check("async_rst_v", 32'(bus.q_valid), 32'h0);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("hold_after_rst_q", 32'(bus.mout_q), 32'h0);
    check("hold_after_rst_v", 32'(bus.q_valid), 32'h0);

    // Capture of B, then hold with en=0
    bus.A  = 10'h155;
    bus.B  = 10'h2AA;
    bus.SW = 1'b1;
    bus.en = 1'b1;
    tick();
    check("cap_b_q", 32'(bus.mout_q), 32'h2AA);
    check("cap_b_v", 32'(bus.q_valid), 32'h1);
    bus.en = 1'b0;
    bus.SW = 1'b0;
    tick();
    tick();
    check("hold_q", 32'(bus.mout_q), 32'h2AA);
    check("hold_mout", 32'(bus.mout), 32'h155);
    check("hold_v", 32'(bus.q_valid), 32'h1);

    // Full-width alternation, mout_q one cycle behind SW
    bus.A  = 10'h3FF;
    bus.B  = 10'h000;
    bus.en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.SW = (i % 2) == 1;
      tick();
      check("alt_q", 32'(bus.mout_q), (i % 2) == 1 ? 32'h000 : 32'h3FF);
    end

`ifdef MUX_2X1_10_SELCNT_EN
    // Counter starts from reset with SW copy at 0
    bus.SW = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("tog_reset", 32'(bus.sel_toggles), 32'h0);
    rst_n = 1'b1;
    tick();
    check("tog_no_change", 32'(bus.sel_toggles), 32'h0);
    bus.SW = 1'b1;
    tick();
    check("tog_first_high", 32'(bus.sel_toggles), 32'h1);
    bus.SW = 1'b0;
    tick();
    check("tog_two", 32'(bus.sel_toggles), 32'h2);
    bus.en = 1'b0;
    bus.SW = 1'b1;
    tick();
    check("tog_ignores_en", 32'(bus.sel_toggles), 32'h3);

    // Saturation after 300 toggles
    for (int i = 0; i < 300; i++) begin
      bus.SW = ~bus.SW;
      tick();
    end
    check("tog_sat", 32'(bus.sel_toggles), 32'hFF);
    bus.SW = ~bus.SW;
    tick();
    check("tog_sat_hold", 32'(bus.sel_toggles), 32'hFF);
    rst_n = 1'b0;
    #1;
    check("tog_sat_reset", 32'(bus.sel_toggles), 32'h0);
    rst_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
